icache_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single memory port between the icache refill path (port 0) and the LSU (port 1). Sits between the icache/LSU and the memory bus. Each granted transaction is forwarded as one registered request and owns the port until its last response beat. Grants alternate round-robin, so a 4-beat icache line refill (16-byte line, 4 words) cannot starve LSU accesses.

---
 rtl/icache_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_icache_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refill (m0) and LSU (m1).
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module icache_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_req_addr,
  input  logic        m0_req_wen,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_wstrb,
  input  logic [1:0]  m0_req_len,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rsp_data,
  output logic        m0_rsp_last,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_req_addr,
  input  logic        m1_req_wen,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wstrb,
  input  logic [1:0]  m1_req_len,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rsp_data,
  output logic        m1_rsp_last,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  output logic [1:0]  mem_req_len,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_last,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  len_q, len_d;
  logic        grant_any, grant_sel, rsp_fwd;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_timeout_q, err_timeout_d;
`endif

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    prio_d          = prio_q;
    mem_req_valid_d = mem_req_valid_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    len_d           = len_q;

    // A lone requester wins regardless of prio; prio only breaks ties.
    grant_any    = m0_req_valid | m1_req_valid;
    grant_sel    = (m0_req_valid & m1_req_valid) ? prio_q : m1_req_valid;
    m0_req_ready = (state_q == IDLE) & grant_any & ~grant_sel;
    m1_req_ready = (state_q == IDLE) & grant_any & grant_sel;

    rsp_fwd      = (state_q == RSP) & mem_rsp_valid;
    m0_rsp_valid = rsp_fwd & ~owner_q;
    m1_rsp_valid = rsp_fwd & owner_q;
    m0_rsp_last  = m0_rsp_valid & mem_rsp_last;
    m1_rsp_last  = m1_rsp_valid & mem_rsp_last;
    m0_rsp_data  = mem_rsp_data;
    m1_rsp_data  = mem_rsp_data;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d         = REQ;
          owner_d         = grant_sel;
          mem_req_valid_d = 1'b1;
          addr_d          = grant_sel ? m1_req_addr  : m0_req_addr;
          wen_d           = grant_sel ? m1_req_wen   : m0_req_wen;
          wdata_d         = grant_sel ? m1_req_wdata : m0_req_wdata;
          wstrb_d         = grant_sel ? m1_req_wstrb : m0_req_wstrb;
          len_d           = grant_sel ? m1_req_len   : m0_req_len;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d         = RSP;
          mem_req_valid_d = 1'b0;
        end
      end
      RSP: begin
        if (mem_rsp_valid && mem_rsp_last) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    // Counter sits at zero while idle, so the first REQ cycle counts as 0;
    // a normal completion in the same cycle takes precedence over the timeout.
    tmo_cnt_d     = tmo_cnt_q;
    err_timeout_d = err_timeout_q;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (state_d != IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        err_timeout_d   = 1'b1;
        state_d         = IDLE;
        mem_req_valid_d = 1'b0;
        prio_d          = ~owner_q;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      prio_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      len_q           <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q       <= '0;
      err_timeout_q   <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      prio_q          <= prio_d;
      mem_req_valid_q <= mem_req_valid_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      len_q           <= len_d;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q       <= tmo_cnt_d;
      err_timeout_q   <= err_timeout_d;
`endif
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign mem_req_len   = len_q;

`ifdef ARB_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_icache_mem_arbiter.sv
`timescale 1ns/1ps

module tb_icache_mem_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req_valid, m0_req_ready, m0_req_wen, m0_rsp_valid, m0_rsp_last;
  logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_data;
  logic [3:0]  m0_req_wstrb;
  logic [1:0]  m0_req_len;
  logic        m1_req_valid, m1_req_ready, m1_req_wen, m1_rsp_valid, m1_rsp_last;
  logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_data;
  logic [3:0]  m1_req_wstrb;
  logic [1:0]  m1_req_len;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic [1:0]  mem_req_len;
  logic        mem_rsp_valid, mem_rsp_last, err_timeout;
  logic [31:0] mem_rsp_data;

  int n_tests = 0;
  int n_fail  = 0;
  int prio_m  = 0;
  int          obs_grant[$];
  logic [31:0] obs_addr[$];

  icache_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
    .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_req_len(m0_req_len), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
    .m0_rsp_last(m0_rsp_last),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
    .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_req_len(m1_req_len), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
    .m1_rsp_last(m1_rsp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_req_len(mem_req_len),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0_req_valid = 0; m0_req_addr = '0; m0_req_wen = 0; m0_req_wdata = '0; m0_req_wstrb = '0; m0_req_len = '0;
    m1_req_valid = 0; m1_req_addr = '0; m1_req_wen = 0; m1_req_wdata = '0; m1_req_wstrb = '0; m1_req_len = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_last = 0;
    tick(); tick();
    reset = 1'b0;
    prio_m = 0;
  endtask

  task automatic rand_req(input int n);
    if (n == 0) begin
      m0_req_addr = $urandom; m0_req_wen = 1'($urandom_range(0, 1)); m0_req_wdata = $urandom;
      m0_req_wstrb = 4'($urandom); m0_req_len = 2'($urandom);
    end else begin
      m1_req_addr = $urandom; m1_req_wen = 1'($urandom_range(0, 1)); m1_req_wdata = $urandom;
      m1_req_wstrb = 4'($urandom); m1_req_len = 2'($urandom);
    end
  endtask

  task automatic check_req(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [1:0] l);
    chk("mem_req_valid", mem_req_valid, 1'b1);
    chk("mem_req_addr", mem_req_addr, a);
    chk("mem_req_wen", mem_req_wen, w);
    chk("mem_req_wdata", mem_req_wdata, wd);
    chk("mem_req_wstrb", mem_req_wstrb, ws);
    chk("mem_req_len", mem_req_len, l);
    chk("busy_ready0", m0_req_ready, 1'b0);
    chk("busy_ready1", m1_req_ready, 1'b0);
  endtask

  task automatic transact(input int stall, input bit gaps, input bit scramble);
    int own, nbeats;
    logic [31:0] e_addr, e_wdata, d;
    logic        e_wen, lst;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_len;
    own = (m0_req_valid && m1_req_valid) ? prio_m : (m1_req_valid ? 1 : 0);
    e_addr  = own ? m1_req_addr  : m0_req_addr;
    e_wen   = own ? m1_req_wen   : m0_req_wen;
    e_wdata = own ? m1_req_wdata : m0_req_wdata;
    e_wstrb = own ? m1_req_wstrb : m0_req_wstrb;
    e_len   = own ? m1_req_len   : m0_req_len;
    nbeats  = e_wen ? 1 : int'(e_len) + 1;
    #1;
    chk("grant_ready0", m0_req_ready, (own == 0));
    chk("grant_ready1", m1_req_ready, (own == 1));
    obs_grant.push_back(m1_req_ready ? 1 : 0);
    tick();
    obs_addr.push_back(mem_req_addr);
    for (int s = 0; s < stall; s++) begin
      mem_req_ready = 0;
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_last  = 1'($urandom_range(0, 1));
      mem_rsp_data  = $urandom;
      if (scramble) begin
        rand_req(0); rand_req(1);
        m0_req_valid = 1'($urandom_range(0, 1));
        m1_req_valid = 1'($urandom_range(0, 1));
      end
      #1;
      check_req(e_addr, e_wen, e_wdata, e_wstrb, e_len);
      chk("req_phase_rsp0", m0_rsp_valid, 1'b0);
      chk("req_phase_rsp1", m1_rsp_valid, 1'b0);
      tick();
    end
    mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_last = 0;
    #1;
    check_req(e_addr, e_wen, e_wdata, e_wstrb, e_len);
    tick();
    mem_req_ready = 0;
    #1;
    chk("req_valid_drop", mem_req_valid, 1'b0);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        mem_rsp_valid = 0; mem_rsp_last = 0; mem_rsp_data = $urandom;
        #1;
        chk("gap_rsp0", m0_rsp_valid, 1'b0);
        chk("gap_rsp1", m1_rsp_valid, 1'b0);
        tick();
      end
      d = $urandom;
      lst = (b == nbeats - 1);
      mem_rsp_valid = 1; mem_rsp_data = d; mem_rsp_last = lst;
      #1;
      chk("rsp_valid0", m0_rsp_valid, (own == 0));
      chk("rsp_valid1", m1_rsp_valid, (own == 1));
      chk("rsp_data0", m0_rsp_data, d);
      chk("rsp_data1", m1_rsp_data, d);
      chk("rsp_last", (own ? m1_rsp_last : m0_rsp_last), lst);
      chk("rsp_ready0", m0_req_ready, 1'b0);
      chk("rsp_ready1", m1_req_ready, 1'b0);
      tick();
    end
    mem_rsp_valid = 0; mem_rsp_last = 0;
    prio_m = 1 - own;
  endtask

  initial begin
    do_reset();
    #1;
    n_tests++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $error("FAIL rst_mem_req_valid: observed=%0h", mem_req_valid); end
    n_tests++;
    if (mem_req_addr !== 32'h0) begin n_fail++; $error("FAIL rst_mem_req_addr: observed=%0h", mem_req_addr); end
    n_tests++;
    if (mem_req_len !== 2'h0) begin n_fail++; $error("FAIL rst_mem_req_len: observed=%0h", mem_req_len); end
    n_tests++;
    if (mem_req_wstrb !== 4'h0) begin n_fail++; $error("FAIL rst_mem_req_wstrb: observed=%0h", mem_req_wstrb); end
    n_tests++;
    if (m0_req_ready !== 1'b0) begin n_fail++; $error("FAIL rst_ready0: observed=%0h", m0_req_ready); end
    n_tests++;
    if (m1_req_ready !== 1'b0) begin n_fail++; $error("FAIL rst_ready1: observed=%0h", m1_req_ready); end
    n_tests++;
    if (m0_rsp_valid !== 1'b0) begin n_fail++; $error("FAIL rst_rsp_valid0: observed=%0h", m0_rsp_valid); end
    n_tests++;
    if (err_timeout !== 1'b0) begin n_fail++; $error("FAIL rst_err: observed=%0h", err_timeout); end

    m0_req_valid = 1; m0_req_addr = 32'h8000_0010; m0_req_len = 2'd3; m0_req_wen = 0;
    obs_addr.delete(); obs_grant.delete();
    transact(0, 0, 0);
    chk("refill_addr", obs_addr[0], 32'h8000_0010);
    m0_req_valid = 0;

    m0_req_addr = 32'h40; m0_req_len = 2'd0;
    m0_req_valid = 1;
    transact(0, 0, 0);
    m0_req_valid = 0;

    do_reset();
    obs_addr.delete(); obs_grant.delete();
    m0_req_valid = 1; m0_req_addr = 32'h100; m0_req_len = 2'd1;
    m1_req_valid = 1; m1_req_addr = 32'h200; m1_req_len = 2'd0;
    for (int i = 0; i < 4; i++) transact(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs_grant[i] != (i % 2)) begin
        n_fail++;
        $error("FAIL fair_grant[%0d]: observed=%0d expected=%0d", i, obs_grant[i], i % 2);
      end
      n_tests++;
      if (obs_addr[i] !== ((i % 2) ? 32'h200 : 32'h100)) begin
        n_fail++;
        $error("FAIL fair_addr[%0d]: observed=%0h", i, obs_addr[i]);
      end
    end
    m0_req_valid = 0; m1_req_valid = 0;

    obs_addr.delete();
    m1_req_valid = 1; m1_req_wen = 1; m1_req_addr = 32'h8000_1000;
    m1_req_wdata = 32'hDEAD_BEEF; m1_req_wstrb = 4'hF; m1_req_len = 2'd0;
    transact(0, 0, 0);
    chk("lsu_wr_addr", obs_addr[0], 32'h8000_1000);
    m1_req_valid = 0;

    m0_req_valid = 1; m0_req_wen = 1; m0_req_addr = 32'h1234_5678;
    m0_req_wdata = 32'hCAFE_F00D; m0_req_wstrb = 4'h3; m0_req_len = 2'd0;
    transact(5, 0, 1);
    m0_req_valid = 0; m1_req_valid = 0;

    tick();
    m0_req_valid = 1; m0_req_wen = 0; m0_req_addr = 32'h8000_0020; m0_req_len = 2'd3;
    #1;
    chk("midrst_grant", m0_req_ready, 1'b1);
    tick();
    m0_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid = 1; mem_rsp_data = 32'h11 * (b + 1); mem_rsp_last = 0;
      #1;
      chk("midrst_fwd", m0_rsp_valid, 1'b1);
      tick();
    end
    mem_rsp_valid = 0; reset = 1;
    tick();
    reset = 0;
    #1;
    chk("midrst_mem_valid", mem_req_valid, 1'b0);
    chk("midrst_mem_addr", mem_req_addr, 32'h0);
    chk("midrst_mem_len", mem_req_len, 2'h0);
    for (int b = 2; b < 4; b++) begin
      mem_rsp_valid = 1; mem_rsp_data = 32'h11 * (b + 1); mem_rsp_last = (b == 3);
      #1;
      chk("midrst_drop0", m0_rsp_valid, 1'b0);
      chk("midrst_drop1", m1_rsp_valid, 1'b0);
      tick();
    end
    mem_rsp_valid = 0; mem_rsp_last = 0;
    prio_m = 0;
    m0_req_valid = 1; m1_req_valid = 1; m0_req_len = 2'd0; m1_req_len = 2'd0;
    transact(0, 0, 0);
    m0_req_valid = 0; m1_req_valid = 0;

`ifndef ARB_TIMEOUT_EN
    m1_req_valid = 1; rand_req(1);
    transact(12, 1, 0);
    m1_req_valid = 0;
    chk("no_timeout_err", err_timeout, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      int v;
      v = $urandom_range(1, 3);
      m0_req_valid = v[0]; m1_req_valid = v[1];
      rand_req(0); rand_req(1);
`ifdef ARB_TIMEOUT_EN
      transact(0, 0, 1);
`else
      transact($urandom_range(0, 3), 1, 1);
`endif
      if ($urandom_range(0, 3) == 0) begin
        m0_req_valid = 0; m1_req_valid = 0;
        #1;
        chk("idle_ready0", m0_req_ready, 1'b0);
        chk("idle_ready1", m1_req_ready, 1'b0);
        tick();
      end
    end
    m0_req_valid = 0; m1_req_valid = 0;

`ifdef ARB_TIMEOUT_EN
    begin
      int own;
      m0_req_valid = 1; m1_req_valid = 1; rand_req(0); rand_req(1);
      own = prio_m;
      #1;
      chk("tmo_grant", (own ? m1_req_ready : m0_req_ready), 1'b1);
      tick();
      mem_req_ready = 1;
      for (int c = 0; c < 8; c++) begin
        #1;
        chk("tmo_not_yet", err_timeout, 1'b0);
        tick();
        mem_req_ready = 0;
      end
      chk("tmo_flag", err_timeout, 1'b1);
      prio_m = 1 - own;
      transact(0, 0, 0);
      chk("tmo_sticky", err_timeout, 1'b1);
      m0_req_valid = 0; m1_req_valid = 0;
      do_reset();
      #1;
      chk("tmo_cleared", err_timeout, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
